instr_mem_banked: RTL and testbench

//  Parametrised multi-bank instruction memory; successor to the fixed 32-bit / 81-word fetch store.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_bank_ram.sv | 31 +++
 rtl/instr_mem_banked.sv | 183 ++++++++++++++++++
 tb/tb_instr_mem_banked.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the banked instruction memory.
//   ld_state_e   loader FSM state (IDLE / LOAD)
//   NOP_WORD_DEF default word returned on a faulting fetch
//   bank_w()     bank-select width for a given bank count (minimum 1)
package imem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } ld_state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_bank_ram.sv
// imem_bank_ram: one program bank, simple dual port (1 write, 1 registered read).
//   clock    rising-edge clock
//   we_i     write enable; waddr_i / wdata_i write address and data
//   re_i     read enable;  raddr_i read address
//   rdata_o  registered read data, updated only when re_i is high (holds otherwise)
// Contents are never reset.
module imem_bank_ram #(
  parameter int  W     = 32,
  parameter int  DEPTH = 128,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_banked.sv
// instr_mem_banked: NBANKS-bank instruction memory, run-time loadable over a
// valid/ready stream, 1-cycle registered fetch.
//   Fetch : fetch_req/fetch_bank/fetch_addr in; instr/instr_valid/fetch_fault out
//           one cycle later. Faults (addr >= DEPTH, bank out of range, or bank
//           currently being loaded) return NOP_WORD with fetch_fault=1.
//   Load  : load_start/load_bank open a load at word 0; load_valid/load_ready/
//           load_data/load_last stream words; load_done pulses after the last
//           word; load_count reports words written.
//   parity_err : sticky read-parity error.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity + parity_err).
// Without it parity_err is tied low and no parity bit is stored.
module instr_mem_banked
  import imem_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 128,
  parameter int              NBANKS   = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  localparam int             BANK_W   = bank_w(NBANKS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [BANK_W-1:0] fetch_bank,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [BANK_W-1:0] load_bank,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              parity_err
);

  localparam int RA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  // Wider-than-address constants so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [BANK_W:0] NBANK_L = (BANK_W+1)'(NBANKS);

  // ---------------- loader FSM ----------------
  ld_state_e         state_q, state_d;
  logic [BANK_W-1:0] ld_bank_q, ld_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   ld_cnt_q, ld_cnt_d;
  logic              ld_done_q, ld_done_d;
  logic              accept, wr_last;

  assign load_ready = (state_q == LOAD);
  assign accept     = load_ready && load_valid;
  // Terminal pointer ends the load even without load_last; the pointer never wraps.
  assign wr_last    = load_last || (wr_ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d   = state_q;
    ld_bank_d = ld_bank_q;
    wr_ptr_d  = wr_ptr_q;
    ld_cnt_d  = ld_cnt_q;
    ld_done_d = 1'b0;
    case (state_q)
      IDLE: if (load_start) begin
        state_d   = LOAD;
        ld_bank_d = load_bank;
        wr_ptr_d  = '0;
        ld_cnt_d  = '0;
      end
      LOAD: if (accept) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        if (wr_last) begin
          state_d   = IDLE;
          ld_done_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_bank_q <= '0;
      wr_ptr_q  <= '0;
      ld_cnt_q  <= '0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_bank_q <= ld_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      ld_cnt_q  <= ld_cnt_d;
      ld_done_q <= ld_done_d;
    end
  end

  assign load_done  = ld_done_q;
  assign load_count = ld_cnt_q;

  // ---------------- fault decode ----------------
  logic addr_oob, bank_oob, bank_busy, fault;

  assign addr_oob  = {1'b0, fetch_addr} >= DEPTH_L;
  // Only reachable when NBANKS is not a power of two; keeps the bank index legal.
  assign bank_oob  = {1'b0, fetch_bank} >= NBANK_L;
  assign bank_busy = (state_q == LOAD) && (fetch_bank == ld_bank_q);
  assign fault     = addr_oob || bank_oob || bank_busy;

  // ---------------- bank array ----------------
  logic [MEM_W-1:0]             wdata;
  logic [NBANKS-1:0][MEM_W-1:0] rdata;

`ifdef IMEM_PARITY_EN
  assign wdata = {^load_data, load_data};
`else
  assign wdata = load_data;
`endif

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    imem_bank_ram #(
      .W     (MEM_W),
      .DEPTH (DEPTH)
    ) u_ram (
      .clock   (clock),
      .we_i    (accept && (ld_bank_q == BANK_W'(b))),
      .waddr_i (wr_ptr_q[RA_W-1:0]),
      .wdata_i (wdata),
      .re_i    (fetch_req && !fault && (fetch_bank == BANK_W'(b))),
      .raddr_i (fetch_addr[RA_W-1:0]),
      .rdata_o (rdata[b])
    );
  end

  // ---------------- read side ----------------
  // nop_q selects NOP_WORD; it and rd_bank_q only move on a request, so with no
  // request instr keeps showing the last fetched word (RAM read regs hold too).
  logic              vld_q, flt_q, nop_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic [MEM_W-1:0]  rsel;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q     <= 1'b0;
      flt_q     <= 1'b0;
      nop_q     <= 1'b1;
      rd_bank_q <= '0;
    end else begin
      vld_q <= fetch_req;
      flt_q <= fetch_req && fault;
      if (fetch_req) begin
        nop_q     <= fault;
        rd_bank_q <= fetch_bank;
      end
    end
  end

  assign rsel        = rdata[rd_bank_q];
  assign instr       = nop_q ? NOP_WORD : rsel[DATA_W-1:0];
  assign instr_valid = vld_q;
  assign fetch_fault = flt_q;

`ifdef IMEM_PARITY_EN
  logic perr_q;
  // Stored word includes its even-parity bit, so a good word XORs to 0.
  always_ff @(posedge clock) begin
    if (reset)                          perr_q <= 1'b0;
    else if (vld_q && !nop_q && ^rsel)  perr_q <= 1'b1;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_banked.sv
// Self-checking bench for instr_mem_banked (DEPTH=128, NBANKS=4, 32-bit words).
module tb_instr_mem_banked;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [1:0]  fetch_bank;
  logic [9:0]  fetch_addr;
  logic [31:0] instr;
  logic        instr_valid, fetch_fault;
  logic        load_start;
  logic [1:0]  load_bank;
  logic        load_valid, load_ready;
  logic [31:0] load_data;
  logic        load_last, load_done;
  logic [10:0] load_count;
  logic        parity_err;

  instr_mem_banked dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_bank(fetch_bank), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_bank(load_bank), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .load_done(load_done), .load_count(load_count), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Stimulus only: present one fetch and record its expected response.
  task automatic drive_fetch(input logic [1:0] b, input logic [9:0] a,
                             input logic [31:0] ei, input logic ef);
    fetch_req  = 1'b1;
    fetch_bank = b;
    fetch_addr = a;
    sb.push_back({ei, ef});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 0; fetch_bank = 0; fetch_addr = 0;
    load_start = 0; load_bank = 0; load_valid = 0; load_data = 0; load_last = 0;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if ({instr_valid, fetch_fault, instr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_fetch: got v=%0b f=%0b i=%h, want 0 0 00000000", instr_valid, fetch_fault, instr);
    end
    checks++;
    if ({load_ready, load_done, load_count, parity_err} !== 14'h0) begin
      errors++; $display("FAIL reset_load: got rdy=%0b done=%0b cnt=%0d perr=%0b, want all 0", load_ready, load_done, load_count, parity_err);
    end
  endtask

  task automatic test_load();
    load_start = 1; load_bank = 0; cyc(); load_start = 0;
    checks++;
    if (load_ready !== 1'b1 || load_count !== 11'd0) begin
      errors++; $display("FAIL load_open: got rdy=%0b cnt=%0d, want 1 0", load_ready, load_count);
    end
    for (int i = 0; i < 10; i++) begin
      load_valid = 1; load_data = 32'(i + 1); load_last = (i == 9);
      cyc();
    end
    load_valid = 0; load_last = 0;
    checks++;
    if ({load_done, load_ready, load_count} !== {1'b1, 1'b0, 11'd10}) begin
      errors++; $display("FAIL load_done: got done=%0b rdy=%0b cnt=%0d, want 1 0 10", load_done, load_ready, load_count);
    end
    cyc();
    checks++;
    if (load_done !== 1'b0 || load_count !== 11'd10) begin
      errors++; $display("FAIL load_done_pulse: got done=%0b cnt=%0d, want 0 10", load_done, load_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int a = 0; a < 10; a++) begin
      drive_fetch(2'd0, 10'(a), 32'(a + 1), 1'b0);
      cyc();
      e = sb.pop_front(); checks++;
      if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
        errors++; $display("FAIL b2b a=%0d: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", a, instr_valid, fetch_fault, instr, e.fault, e.instr);
      end
    end
    fetch_req = 0; cyc();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'hA) begin
      errors++; $display("FAIL hold: got v=%0b i=%h, want v=0 i=0000000a", instr_valid, instr);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [9:0] addrs [3];
    addrs[0] = 10'd128; addrs[1] = 10'd3; addrs[2] = 10'd1023;
    for (int k = 0; k < 3; k++) begin
      if (addrs[k] >= 10'd128) drive_fetch(2'd0, addrs[k], 32'h0, 1'b1);
      else                     drive_fetch(2'd0, addrs[k], 32'(addrs[k]) + 1, 1'b0);
      cyc();
      e = sb.pop_front(); checks++;
      if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
        errors++; $display("FAIL oob a=%0d: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", addrs[k], instr_valid, fetch_fault, instr, e.fault, e.instr);
      end
    end
    fetch_req = 0; cyc();
  endtask

  task automatic test_concurrent();
    exp_t e;
    load_start = 1; load_bank = 1; cyc(); load_start = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1; load_data = 32'h100 + 32'(i); load_last = (i == 5);
      if (i % 2 == 0) drive_fetch(2'd0, 10'(i), 32'(i + 1), 1'b0);
      else            drive_fetch(2'd1, 10'(i), 32'h0, 1'b1);
      cyc();
      e = sb.pop_front(); checks++;
      if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
        errors++; $display("FAIL conc i=%0d: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", i, instr_valid, fetch_fault, instr, e.fault, e.instr);
      end
    end
    load_valid = 0; load_last = 0; fetch_req = 0;
    checks++;
    if (load_done !== 1'b1 || load_count !== 11'd6) begin
      errors++; $display("FAIL conc_done: got done=%0b cnt=%0d, want 1 6", load_done, load_count);
    end
    for (int i = 0; i < 6; i++) begin
      drive_fetch(2'd1, 10'(i), 32'h100 + 32'(i), 1'b0);
      cyc();
      e = sb.pop_front(); checks++;
      if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
        errors++; $display("FAIL bank1 a=%0d: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", i, instr_valid, fetch_fault, instr, e.fault, e.instr);
      end
    end
    fetch_req = 0; cyc();
  endtask

  task automatic test_overflow();
    exp_t e;
    int   acc = 0;
    int   cycles = 0;
    logic rdy;
    load_start = 1; load_bank = 2; cyc(); load_start = 0;
    while (acc < 200 && cycles < 300) begin
      load_valid = 1; load_data = 32'h2000 + 32'(acc); load_last = 0;
      rdy = load_ready;
      cyc(); cycles++;
      if (rdy) acc++;
      if (!load_ready) break;
    end
    load_valid = 0;
    checks++;
    if (acc != 128 || load_count !== 11'd128 || load_ready !== 1'b0 || load_done !== 1'b1) begin
      errors++; $display("FAIL overflow: got acc=%0d cnt=%0d rdy=%0b done=%0b, want 128 128 0 1", acc, load_count, load_ready, load_done);
    end
    drive_fetch(2'd2, 10'd127, 32'h2000 + 32'd127, 1'b0); cyc();
    e = sb.pop_front(); checks++;
    if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
      errors++; $display("FAIL ovf_last: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", instr_valid, fetch_fault, instr, e.fault, e.instr);
    end
    drive_fetch(2'd2, 10'd0, 32'h2000, 1'b0); cyc();
    e = sb.pop_front(); checks++;
    if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
      errors++; $display("FAIL ovf_first: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", instr_valid, fetch_fault, instr, e.fault, e.instr);
    end
    fetch_req = 0; cyc();
  endtask

  task automatic test_reset_midload();
    exp_t e;
    load_start = 1; load_bank = 3; cyc(); load_start = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = 32'h300 + 32'(i); load_last = 0; cyc();
    end
    // Fetch in flight on the reset edge must not produce a valid.
    drive_fetch(2'd0, 10'd1, 32'h2, 1'b0);
    load_data = 32'hDEAD; reset = 1; cyc();
    void'(sb.pop_front());
    reset = 0; load_valid = 0; fetch_req = 0;
    checks++;
    if ({load_ready, load_done, load_count, instr_valid, fetch_fault, instr} !== 47'h0) begin
      errors++; $display("FAIL midload_reset: got rdy=%0b done=%0b cnt=%0d v=%0b f=%0b i=%h, want all 0",
                         load_ready, load_done, load_count, instr_valid, fetch_fault, instr);
    end
    for (int i = 0; i < 3; i++) begin
      drive_fetch(2'd3, 10'(i), 32'h300 + 32'(i), 1'b0); cyc();
      e = sb.pop_front(); checks++;
      if ({instr_valid, fetch_fault, instr} !== {1'b1, e.fault, e.instr}) begin
        errors++; $display("FAIL kept a=%0d: got v=%0b f=%0b i=%h, want v=1 f=%0b i=%h", i, instr_valid, fetch_fault, instr, e.fault, e.instr);
      end
    end
    fetch_req = 0; cyc();
    checks++;
    if (parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_clean: got %0b, want 0", parity_err);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    dut.g_bank[0].u_ram.mem[4] = dut.g_bank[0].u_ram.mem[4] ^ 33'h1;
    drive_fetch(2'd0, 10'd4, 32'h4, 1'b0); cyc();
    void'(sb.pop_front());
    fetch_req = 0; cyc(); cyc();
    checks++;
    if (parity_err !== 1'b1) begin
      errors++; $display("FAIL parity_set: got %0b, want 1", parity_err);
    end
    reset = 1; cyc(); reset = 0;
    checks++;
    if (parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_clear: got %0b, want 0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_out_of_range();
    test_concurrent();
    test_overflow();
    test_reset_midload();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
